ahb_mem_slave: RTL and testbench
================================

Name: ahb_mem_slave

Overview:
- AHB-Lite responder (data memory) at the far end of the HTRANS/HWRITE transfers issued by the processor's micro-sequenced load/store control.
- Captures the address phase, then completes the data phase with optional wait states and an OKAY or ERROR response.
- Holds a byte-addressable word RAM that serves LW/SW and the byte/halfword variants.

Parameters:
- MEM_BYTES, 1024: RAM size in bytes; a multiple of 4 and a power of 2.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase (0..7).
- ADDR_W, 32: HADDR width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address, address phase.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, address phase.
- HSIZE  in  3  000 byte, 001 half, 010 word; others illegal.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus ready (previous transfer complete).
- HRDATA  out  32  read data.
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (rst low, async): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, captured registers cleared. RAM contents are not reset.
- Address-phase accept: HSEL & HREADY & HTRANS[1] at a clk edge. The edge latches HADDR, HWRITE and HSIZE into dp_addr, dp_write and dp_size.
- IDLE and BUSY transfers, or HSEL=0, are not accepted and get a zero-wait OKAY.
- Error detection at accept: an access errors if any of these hold:
  - address >= MEM_BYTES;
  - HSIZE > 010;
  - the access is misaligned (see Optional Feature).
- State machine: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on a legal accept, go to WAIT if WAIT_STATES>0, else DATA. On an error accept, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter counts down from WAIT_STATES-1; at 0, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0.
    - Read: HRDATA = RAM word at dp_addr[..:2]. The full word is driven; the master selects lanes.
    - Write: at the end of this cycle, HWDATA byte lanes are written per dp_size and dp_addr[1:0]. Byte writes lane addr[1:0]; half writes lanes {addr[1],0} and +1; word writes all 4 lanes.
    - The same edge may accept the next transfer (pipelined). Next state follows the IDLE rules, otherwise IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No RAM write. May accept a new transfer, following the IDLE rules.
- Latency: with WAIT_STATES=0, a read returns data in the cycle after the address phase. A write commits at the edge ending that cycle.
- Write-then-read hazard: a write to A followed back-to-back by a read of A must return the new data. The RAM is read combinationally from dp_addr after the write edge.
- HRDATA outside a read DATA cycle holds its last value.
- An accept with HREADY=0 is ignored.
- Reset mid-transfer aborts with no RAM write and returns to IDLE.

Optional Feature:
- Macro: AHB_MISALIGN_ERR_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, gets the two-cycle ERROR response and no write.
- Undefined: low address bits are masked to natural alignment (half clears bit 0, word clears bits 1:0) and the access completes OKAY.

Test Plan:
- WAIT_STATES=0: NONSEQ write word 0xDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back. Required: HREADYOUT stays 1, HRESP=0, HRDATA=0xDEADBEEF in the read data cycle.
- Byte write 0xAA @0x13 over word 0x11223344, then word read @0x10. Required: HRDATA=0xAA223344.
- WAIT_STATES=2: read @0x10. Required: HREADYOUT 0,0,1 over three cycles; HRDATA valid on the third.
- Read @MEM_BYTES (0x400). Required: HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; RAM unchanged.
- Word write @0x12. Required with AHB_MISALIGN_ERR_EN: ERROR pair, RAM unchanged. Required without it: OKAY, data written @0x10.
- Assert rst low during a WAIT cycle of a write. Required: immediately HREADYOUT=1, HRESP=0; the target word is unchanged after release.

Source files
------------

// File: rtl/ahb_mem_slave.sv
// AHB-Lite data-memory responder: byte-addressable word RAM with optional wait states and ERROR response.
// Optional macro AHB_MISALIGN_ERR_EN: misaligned half/word accesses return ERROR instead of being masked.
module ahb_mem_slave #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int unsigned BYTE_AW = $clog2(MEM_BYTES);
    localparam int unsigned WORD_AW = BYTE_AW - 2;
    localparam int unsigned WORDS   = MEM_BYTES / 4;
    localparam int unsigned CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam bit HAS_WAIT = (WAIT_STATES > 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BYTE_AW-1:0] r_dp_addr;
    logic               r_dp_write;
    logic [1:0]         r_dp_size;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hrdata_hold;
    logic               r_hreadyout;
    logic               r_hresp;
    logic [31:0]        r_mem [WORDS];

    logic               w_can_accept;
    logic               w_accept;
    logic               w_addr_oor;
    logic               w_misalign;
    logic               w_err;
    logic               w_next_ready;
    logic               w_next_resp;
    logic [3:0]         w_be;
    logic [WORD_AW-1:0] w_word_idx;
    logic [31:0]        w_rd_word;
    logic               w_rd_active;

    // Address-phase accept and error classification
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_accept     = HSEL && HREADY && ((HTRANS == 2'b10) || (HTRANS == 2'b11)) && w_can_accept;
    assign w_addr_oor   = (HADDR >= ADDR_W'(MEM_BYTES));
`ifdef AHB_MISALIGN_ERR_EN
    assign w_misalign   = ((HSIZE == 3'b001) && HADDR[0]) ||
                          ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
`else
    assign w_misalign   = 1'b0;
`endif
    assign w_err        = w_addr_oor || (HSIZE > 3'b010) || w_misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_next_ready = 1'b1;
        w_next_resp  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (w_accept) begin
                    if (w_err)         w_next = ST_ERR1;
                    else if (HAS_WAIT) w_next = ST_WAIT;
                    else               w_next = ST_DATA;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: w_next = (r_cnt == '0) ? ST_DATA : ST_WAIT;
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
        w_next_ready = !((w_next == ST_WAIT) || (w_next == ST_ERR1));
        w_next_resp  = (w_next == ST_ERR1) || (w_next == ST_ERR2);
    end

    // Data-phase context, wait counter and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dp_addr     <= '0;
            r_dp_write    <= 1'b0;
            r_dp_size     <= 2'b00;
            r_cnt         <= '0;
            r_hrdata_hold <= '0;
            r_hreadyout   <= 1'b1;
            r_hresp       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dp_addr  <= HADDR[BYTE_AW-1:0];
                r_dp_write <= HWRITE;
                r_dp_size  <= HSIZE[1:0];
            end
            if ((w_next == ST_WAIT) && (r_state != ST_WAIT)) begin
                r_cnt <= CNT_INIT;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_rd_active) begin
                r_hrdata_hold <= w_rd_word;
            end
            r_hreadyout <= w_next_ready;
            r_hresp     <= w_next_resp;
        end
    end

    // Lane enables; low address bits beyond natural alignment are ignored
    always_comb begin
        w_be = 4'b0000;
        case (r_dp_size)
            2'b00:   w_be = 4'b0001 << r_dp_addr[1:0];
            2'b01:   w_be = r_dp_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_word_idx = r_dp_addr[BYTE_AW-1:2];

    // RAM is not reset; reset holds the FSM out of DATA so no write can occur
    always_ff @(posedge clk) begin
        if ((r_state == ST_DATA) && r_dp_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Combinational read so a write committed on the previous edge is visible immediately
    assign w_rd_word   = r_mem[w_word_idx];
    assign w_rd_active = (r_state == ST_DATA) && !r_dp_write;
    assign HRDATA      = w_rd_active ? w_rd_word : r_hrdata_hold;
    assign HREADYOUT   = r_hreadyout;
    assign HRESP       = r_hresp;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: a zero-wait instance and a two-wait-state instance.
// Honours AHB_MISALIGN_ERR_EN when choosing expectations for the misaligned word write.
module tb_ahb_mem_slave;

    logic        clk;
    logic        rst;
    logic        hsel0;
    logic        hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready_en0;
    logic        hready0;
    logic        hready2;
    logic [31:0] hrdata0;
    logic [31:0] hrdata2;
    logic        ready0;
    logic        ready2;
    logic        resp0;
    logic        resp2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp10;
    logic [31:0] rd;

    assign hready0 = ready0 & hready_en0;
    assign hready2 = ready2;

    ahb_mem_slave #(.MEM_BYTES(1024), .WAIT_STATES(0), .ADDR_W(32)) dut0 (
        .clk(clk), .rst(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0),
        .HRDATA(hrdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahb_mem_slave #(.MEM_BYTES(1024), .WAIT_STATES(2), .ADDR_W(32)) dut2 (
        .clk(clk), .rst(rst), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready2),
        .HRDATA(hrdata2), .HREADYOUT(ready2), .HRESP(resp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_ph(input logic s0, input logic s2, input logic [1:0] tr,
                           input logic wr, input logic [2:0] sz, input logic [31:0] a);
        hsel0  = s0;
        hsel2  = s2;
        htrans = tr;
        hwrite = wr;
        hsize  = sz;
        haddr  = a;
    endtask

    task automatic idle_ph();
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic write0(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        addr_ph(1'b1, 1'b0, 2'b10, 1'b1, sz, a);
        tick();
        hwdata = d;
        idle_ph();
        tick();
    endtask

    task automatic read0(input logic [31:0] a, output logic [31:0] d);
        addr_ph(1'b1, 1'b0, 2'b10, 1'b0, 3'b010, a);
        tick();
        idle_ph();
        d = hrdata0;
        tick();
    endtask

    task automatic read2(input logic [31:0] a, output logic [31:0] d);
        addr_ph(1'b0, 1'b1, 2'b10, 1'b0, 3'b010, a);
        tick();
        idle_ph();
        repeat (2) tick();
        d = hrdata2;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hready_en0 = 1'b1;
        hwdata = '0;
        addr_ph(1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
        repeat (2) tick();
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b0) begin
            $display("FAIL reset_hs0: got ready=%b resp=%b expected 1/0", ready0, resp0);
            n_fail++;
        end
        n_checks++;
        if (hrdata0 !== 32'h0) begin
            $display("FAIL reset_hrdata0: got %h expected 00000000", hrdata0);
            n_fail++;
        end
        n_checks++;
        if (ready2 !== 1'b1 || resp2 !== 1'b0 || hrdata2 !== 32'h0) begin
            $display("FAIL reset_dut2: got ready=%b resp=%b hrdata=%h expected 1/0/0", ready2, resp2, hrdata2);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        addr_ph(1'b1, 1'b0, 2'b10, 1'b1, 3'b010, 32'h10);
        tick();
        hwdata = 32'hDEADBEEF;
        addr_ph(1'b1, 1'b0, 2'b10, 1'b0, 3'b010, 32'h10);
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b0) begin
            $display("FAIL b2b_write_phase: got ready=%b resp=%b expected 1/0", ready0, resp0);
            n_fail++;
        end
        tick();
        idle_ph();
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b0) begin
            $display("FAIL b2b_read_phase: got ready=%b resp=%b expected 1/0", ready0, resp0);
            n_fail++;
        end
        n_checks++;
        if (hrdata0 !== 32'hDEADBEEF) begin
            $display("FAIL b2b_read_data: got %h expected deadbeef", hrdata0);
            n_fail++;
        end
        tick();
        n_checks++;
        if (hrdata0 !== 32'hDEADBEEF) begin
            $display("FAIL hrdata_hold: got %h expected deadbeef", hrdata0);
            n_fail++;
        end
    endtask

    task automatic test_byte_half();
        write0(32'h10, 3'b010, 32'h11223344);
        write0(32'h13, 3'b000, 32'hAA555555);
        read0(32'h10, rd);
        n_checks++;
        if (rd !== 32'hAA223344) begin
            $display("FAIL byte_lane3: got %h expected aa223344", rd);
            n_fail++;
        end
        write0(32'h14, 3'b010, 32'h01020304);
        write0(32'h16, 3'b001, 32'hCAFE5555);
        read0(32'h14, rd);
        n_checks++;
        if (rd !== 32'hCAFE0304) begin
            $display("FAIL half_upper: got %h expected cafe0304", rd);
            n_fail++;
        end
        exp10 = 32'hAA223344;
    endtask

    task automatic test_misalign();
        addr_ph(1'b1, 1'b0, 2'b10, 1'b1, 3'b010, 32'h12);
        tick();
        hwdata = 32'h12345678;
        idle_ph();
`ifdef AHB_MISALIGN_ERR_EN
        n_checks++;
        if (ready0 !== 1'b0 || resp0 !== 1'b1) begin
            $display("FAIL misalign_err1: got ready=%b resp=%b expected 0/1", ready0, resp0);
            n_fail++;
        end
        tick();
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b1) begin
            $display("FAIL misalign_err2: got ready=%b resp=%b expected 1/1", ready0, resp0);
            n_fail++;
        end
        tick();
`else
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b0) begin
            $display("FAIL misalign_okay: got ready=%b resp=%b expected 1/0", ready0, resp0);
            n_fail++;
        end
        tick();
        exp10 = 32'h12345678;
`endif
        read0(32'h10, rd);
        n_checks++;
        if (rd !== exp10) begin
            $display("FAIL misalign_ram: got %h expected %h", rd, exp10);
            n_fail++;
        end
    endtask

    task automatic test_errors();
        write0(32'h0, 3'b010, 32'h0F0F0F0F);
        addr_ph(1'b1, 1'b0, 2'b10, 1'b0, 3'b010, 32'h400);
        tick();
        idle_ph();
        n_checks++;
        if (ready0 !== 1'b0 || resp0 !== 1'b1) begin
            $display("FAIL oor_read_err1: got ready=%b resp=%b expected 0/1", ready0, resp0);
            n_fail++;
        end
        tick();
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b1) begin
            $display("FAIL oor_read_err2: got ready=%b resp=%b expected 1/1", ready0, resp0);
            n_fail++;
        end
        tick();
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b0) begin
            $display("FAIL oor_after: got ready=%b resp=%b expected 1/0", ready0, resp0);
            n_fail++;
        end
        addr_ph(1'b1, 1'b0, 2'b10, 1'b1, 3'b010, 32'h400);
        tick();
        hwdata = 32'hBADBAD00;
        idle_ph();
        repeat (2) tick();
        read0(32'h0, rd);
        n_checks++;
        if (rd !== 32'h0F0F0F0F) begin
            $display("FAIL oor_write_ram: got %h expected 0f0f0f0f", rd);
            n_fail++;
        end
        addr_ph(1'b1, 1'b0, 2'b10, 1'b1, 3'b011, 32'h0);
        tick();
        hwdata = 32'hFFFFFFFF;
        idle_ph();
        n_checks++;
        if (ready0 !== 1'b0 || resp0 !== 1'b1) begin
            $display("FAIL hsize_err1: got ready=%b resp=%b expected 0/1", ready0, resp0);
            n_fail++;
        end
        repeat (2) tick();
        read0(32'h0, rd);
        n_checks++;
        if (rd !== 32'h0F0F0F0F) begin
            $display("FAIL hsize_ram: got %h expected 0f0f0f0f", rd);
            n_fail++;
        end
    endtask

    task automatic test_not_accepted();
        addr_ph(1'b1, 1'b0, 2'b00, 1'b1, 3'b010, 32'h400);
        tick();
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b0) begin
            $display("FAIL idle_okay: got ready=%b resp=%b expected 1/0", ready0, resp0);
            n_fail++;
        end
        addr_ph(1'b1, 1'b0, 2'b01, 1'b1, 3'b010, 32'h400);
        tick();
        n_checks++;
        if (ready0 !== 1'b1 || resp0 !== 1'b0) begin
            $display("FAIL busy_okay: got ready=%b resp=%b expected 1/0", ready0, resp0);
            n_fail++;
        end
        addr_ph(1'b0, 1'b0, 2'b10, 1'b1, 3'b010, 32'h10);
        tick();
        hwdata = 32'hFFFFFFFF;
        idle_ph();
        tick();
        hready_en0 = 1'b0;
        addr_ph(1'b1, 1'b0, 2'b10, 1'b1, 3'b010, 32'h10);
        tick();
        hready_en0 = 1'b1;
        hwdata = 32'hFFFFFFFF;
        idle_ph();
        tick();
        read0(32'h10, rd);
        n_checks++;
        if (rd !== exp10) begin
            $display("FAIL unselected_or_hready0: got %h expected %h", rd, exp10);
            n_fail++;
        end
    endtask

    task automatic test_wait_states();
        addr_ph(1'b0, 1'b1, 2'b10, 1'b1, 3'b010, 32'h10);
        tick();
        hwdata = 32'h5A5AA5A5;
        idle_ph();
        repeat (3) tick();
        addr_ph(1'b0, 1'b1, 2'b10, 1'b0, 3'b010, 32'h10);
        tick();
        idle_ph();
        n_checks++;
        if (ready2 !== 1'b0 || resp2 !== 1'b0) begin
            $display("FAIL ws_cycle1: got ready=%b resp=%b expected 0/0", ready2, resp2);
            n_fail++;
        end
        tick();
        n_checks++;
        if (ready2 !== 1'b0) begin
            $display("FAIL ws_cycle2: got ready=%b expected 0", ready2);
            n_fail++;
        end
        tick();
        n_checks++;
        if (ready2 !== 1'b1 || resp2 !== 1'b0 || hrdata2 !== 32'h5A5AA5A5) begin
            $display("FAIL ws_cycle3: got ready=%b resp=%b data=%h expected 1/0/5a5aa5a5", ready2, resp2, hrdata2);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        addr_ph(1'b0, 1'b1, 2'b10, 1'b1, 3'b010, 32'h10);
        tick();
        hwdata = 32'hFFFFFFFF;
        idle_ph();
        n_checks++;
        if (ready2 !== 1'b0) begin
            $display("FAIL mid_wait_entry: got ready=%b expected 0", ready2);
            n_fail++;
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ready2 !== 1'b1 || resp2 !== 1'b0 || hrdata2 !== 32'h0) begin
            $display("FAIL mid_reset_outputs: got ready=%b resp=%b data=%h expected 1/0/0", ready2, resp2, hrdata2);
            n_fail++;
        end
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        read2(32'h10, rd);
        n_checks++;
        if (rd !== 32'h5A5AA5A5) begin
            $display("FAIL mid_reset_ram: got %h expected 5a5aa5a5", rd);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_half();
        test_misalign();
        test_errors();
        test_not_accepted();
        test_wait_states();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
